// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_arbiter
//  Purpose  : Shares a single register-block access port between NUM_REQ
//             requesters. A round-robin pointer picks the next requester in
//             IDLE. Each granted transaction then runs through a fixed
//             ACCESS / WAIT / DONE sequence, so a registered read strobe on
//             the register side lines up with the captured read data.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             req_valid/wr      - per-requester request and direction
//             req_addr/wdata    - flattened per-requester payload
//             req_ready         - one-hot accept pulse (ACCESS cycle)
//             rsp_valid/rdata   - one-hot completion pulse plus read data
//             reg_addr/wr_sel/wr_rd/wr_data - register decode access port
//             reg_rd_out        - read data from register decode
//             busy              - high whenever a transaction is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [REG_WIDTH-1:0]          rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         reg_addr,
    output logic                          reg_wr_sel,
    output logic                          reg_wr_rd,
    output logic [REG_WIDTH-1:0]          reg_wr_data,
    input  logic [REG_WIDTH-1:0]          reg_rd_out,
    output logic                          busy
);

    localparam int c_PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_PTR_W-1:0]    r_grant;
    logic                  r_wr;
    logic                  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0]  r_wdata;
    logic [REG_WIDTH-1:0]  r_rdata;

    logic                  w_any;
    logic [c_PTR_W-1:0]    w_pick;
    logic [c_PTR_W-1:0]    w_ptr_next;

    // Index base+off modulo NUM_REQ. The wrap is explicit so that non
    // power-of-two requester counts never select a nonexistent requester.
    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return c_PTR_W'(s);
    endfunction

    // First active requester scanning ptr, ptr+1, ... (mod NUM_REQ).
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[f_wrap(r_ptr, k)]) begin
                w_any  = 1'b1;
                w_pick = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_ptr_next = (r_grant == c_PTR_W'(NUM_REQ - 1)) ? '0
                                                           : r_grant + c_PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_wr    <= 1'b0;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_sel <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_wr    <= req_wr[w_pick];
                        r_addr  <= req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= req_wdata[int'(w_pick)*REG_WIDTH +: REG_WIDTH];
                        // Strobe is registered so it is high exactly in ACCESS.
                        r_sel   <= 1'b1;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Register side presents its registered read data here.
                    r_rdata <= r_wr ? '0 : reg_rd_out;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // One-hot pulses decoded from registered state and grant only.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_onehot
        assign req_ready[i] = (r_state == c_ACCESS) && (r_grant == c_PTR_W'(i));
        assign rsp_valid[i] = (r_state == c_DONE)   && (r_grant == c_PTR_W'(i));
    end

    assign reg_wr_sel  = r_sel;
    assign reg_wr_rd   = r_wr;
    assign reg_addr    = r_addr;
    assign reg_wr_data = r_wdata;
    assign rsp_rdata   = r_rdata;
    assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire
